mc_control_fsm: RTL

Multicycle main control unit that drives the datapath of the base processor and issues the 3-bit `alu_func` code consumed by the ALU. It decodes the instruction register's `opcode` and `funct` fields and sequences each instruction through fetch, decode, execute, memory and write-back states. All datapath enables and multiplexer selects are Moore outputs of the state register.

---
 rtl/mc_control_fsm.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// ============================================================================
// mc_control_fsm : multicycle main control unit, Moore outputs + ALU func code
// Optional feature macro: IMM_LOGIC_EN (andi/ori/xori with zero-extension)
// Revision: 1.0
// ============================================================================
`default_nettype none

module mc_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic       imm_zext,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_func,
    output logic [3:0] state,
    output logic       illegal
);

    localparam logic [3:0] c_FETCH  = 4'd0;
    localparam logic [3:0] c_DECODE = 4'd1;
    localparam logic [3:0] c_MEMADR = 4'd2;
    localparam logic [3:0] c_MEMRD  = 4'd3;
    localparam logic [3:0] c_MEMWB  = 4'd4;
    localparam logic [3:0] c_MEMWR  = 4'd5;
    localparam logic [3:0] c_REXEC  = 4'd6;
    localparam logic [3:0] c_RWB    = 4'd7;
    localparam logic [3:0] c_BRANCH = 4'd8;
    localparam logic [3:0] c_JUMP   = 4'd9;
    localparam logic [3:0] c_IEXEC  = 4'd10;
    localparam logic [3:0] c_IWB    = 4'd11;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_XORI  = 6'b001110;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_XOR = 3'b100;
    localparam logic [2:0] c_ALU_NOR = 3'b101;
    localparam logic [2:0] c_ALU_SLL = 3'b110;
    localparam logic [2:0] c_ALU_SRL = 3'b111;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [2:0] r_func;
    logic [1:0] r_kind;
    logic       r_illegal;

    logic [2:0] w_rfunc;
    logic       w_rfunc_ok;
    logic [1:0] w_ikind;
    logic [3:0] w_dec_next;

    logic       w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write;
    logic       w_ir_write, w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a;
    logic       w_imm_zext;
    logic [1:0] w_alu_src_b, w_pc_source;
    logic [2:0] w_alu_func;

    // Instruction decode; an instruction is illegal exactly when DECODE falls back to FETCH.
    always_comb begin
        w_rfunc    = c_ALU_ADD;
        w_rfunc_ok = 1'b1;
        case (funct)
            6'b100000: w_rfunc = c_ALU_ADD;
            6'b100010: w_rfunc = c_ALU_SUB;
            6'b100100: w_rfunc = c_ALU_AND;
            6'b100101: w_rfunc = c_ALU_OR;
            6'b100110: w_rfunc = c_ALU_XOR;
            6'b100111: w_rfunc = c_ALU_NOR;
            6'b000000: w_rfunc = c_ALU_SLL;
            6'b000010: w_rfunc = c_ALU_SRL;
            default:   w_rfunc_ok = 1'b0;
        endcase

        w_ikind    = 2'd0;
        w_dec_next = c_FETCH;
        case (opcode)
            c_OP_LW, c_OP_SW: w_dec_next = c_MEMADR;
            c_OP_RTYPE:       w_dec_next = w_rfunc_ok ? c_REXEC : c_FETCH;
            c_OP_BEQ:         w_dec_next = c_BRANCH;
            c_OP_J:           w_dec_next = c_JUMP;
            c_OP_ADDI:        w_dec_next = c_IEXEC;
`ifdef IMM_LOGIC_EN
            c_OP_ANDI: begin w_dec_next = c_IEXEC; w_ikind = 2'd1; end
            c_OP_ORI:  begin w_dec_next = c_IEXEC; w_ikind = 2'd2; end
            c_OP_XORI: begin w_dec_next = c_IEXEC; w_ikind = 2'd3; end
`endif
            default:          w_dec_next = c_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = c_FETCH;
        case (r_state)
            c_FETCH:  w_next_state = c_DECODE;
            c_DECODE: w_next_state = w_dec_next;
            c_MEMADR: w_next_state = (opcode == c_OP_SW) ? c_MEMWR : c_MEMRD;
            c_MEMRD:  w_next_state = c_MEMWB;
            c_REXEC:  w_next_state = c_RWB;
            c_IEXEC:  w_next_state = c_IWB;
            default:  w_next_state = c_FETCH;
        endcase
    end

    // Operation fields are captured in DECODE so execute states ignore later IR changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_func    <= 3'd0;
            r_kind    <= 2'd0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= (r_state == c_DECODE) && (w_dec_next == c_FETCH);
            if (r_state == c_DECODE) begin
                r_func <= w_rfunc;
                r_kind <= w_ikind;
            end
        end
    end

    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_dst       = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_imm_zext      = 1'b0;
        w_alu_src_b     = 2'b00;
        w_pc_source     = 2'b00;
        w_alu_func      = c_ALU_ADD;
        case (r_state)
            c_FETCH: begin
                w_mem_read  = 1'b1;
                w_ir_write  = 1'b1;
                w_pc_write  = 1'b1;
                w_alu_src_b = 2'b01;
            end
            c_DECODE: w_alu_src_b = 2'b11;
            c_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            c_MEMRD: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
            end
            c_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            c_MEMWR: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
            end
            c_REXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_func  = r_func;
            end
            c_RWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            c_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_func      = c_ALU_SUB;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
            end
            c_JUMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
            end
            c_IEXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                case (r_kind)
                    2'd1:    w_alu_func = c_ALU_AND;
                    2'd2:    w_alu_func = c_ALU_OR;
                    2'd3:    w_alu_func = c_ALU_XOR;
                    default: w_alu_func = c_ALU_ADD;
                endcase
`ifdef IMM_LOGIC_EN
                w_imm_zext = (r_kind != 2'd0);
`endif
            end
            c_IWB: w_reg_write = 1'b1;
            default: ;
        endcase
    end

    // rst_n gating keeps every control low while reset is held, independent of the clock.
    assign pc_write      = w_pc_write      & rst_n;
    assign pc_write_cond = w_pc_write_cond & rst_n;
    assign i_or_d        = w_i_or_d        & rst_n;
    assign mem_read      = w_mem_read      & rst_n;
    assign mem_write     = w_mem_write     & rst_n;
    assign ir_write      = w_ir_write      & rst_n;
    assign mem_to_reg    = w_mem_to_reg    & rst_n;
    assign reg_dst       = w_reg_dst       & rst_n;
    assign reg_write     = w_reg_write     & rst_n;
    assign alu_src_a     = w_alu_src_a     & rst_n;
    assign imm_zext      = w_imm_zext      & rst_n;
    assign alu_src_b     = w_alu_src_b     & {2{rst_n}};
    assign pc_source     = w_pc_source     & {2{rst_n}};
    assign alu_func      = w_alu_func      & {3{rst_n}};
    assign state         = r_state;
    assign illegal       = r_illegal;

endmodule

`default_nettype wire
